// File: rtl/control_unit.sv
// Multicycle accumulator-machine control unit: one FSM that sequences fetch,
// decode, memory access and execute, and drives datapath strobes per state.
module control_unit #(
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] Op,
  input  logic       MemReady,
  input  logic       AccZero,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       PCWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [2:0] AccSrc,
  output logic       AccWrite,
  output logic       SpWrite,
  output logic       Halted,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_RD  = 4'd2,
    MEM_WB  = 4'd3,
    MEM_WR  = 4'd4,
    ALU_EX  = 4'd5,
    BRANCH  = 4'd6,
    SP_EX   = 4'd7,
    HALT    = 4'd8,
    ILLEGAL = 4'd9
  } stateT;

  localparam logic [7:0] OP_LI    = 8'h01;
  localparam logic [7:0] OP_LUI   = 8'h02;
  localparam logic [7:0] OP_LW    = 8'h03;
  localparam logic [7:0] OP_SW    = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDI  = 8'h06;
  localparam logic [7:0] OP_BEQZ  = 8'h07;
  localparam logic [7:0] OP_ADDSP = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;

  stateT state;

  // Defined opcodes take priority should HALT_OP ever be overridden onto one.
  function automatic stateT decodeNext(input logic [7:0] opcode);
    case (opcode)
      OP_LI, OP_LUI:         decodeNext = FETCH;
      OP_LW, OP_ADD, OP_SUB: decodeNext = MEM_RD;
      OP_SW:                 decodeNext = MEM_WR;
      OP_ADDI:               decodeNext = ALU_EX;
      OP_BEQZ:               decodeNext = BRANCH;
      OP_ADDSP:              decodeNext = SP_EX;
      HALT_OP:               decodeNext = HALT;
      default:               decodeNext = ILLEGAL;
    endcase
  endfunction

  // NOTE: state is sequential, so it is written only with non-blocking
  // assignments; blocking here would race with readers on the same edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (MemReady) state <= DECODE;
        DECODE:  state <= decodeNext(Op);
        MEM_RD:  if (MemReady) state <= (Op == OP_LW) ? MEM_WB : ALU_EX;
        MEM_WR:  if (MemReady) state <= FETCH;
        MEM_WB, ALU_EX, BRANCH, SP_EX: state <= FETCH;
        HALT:    state <= HALT;
        ILLEGAL: state <= ILLEGAL;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are decoded from state plus live inputs: load enables must react
  // to MemReady/AccZero within the same cycle, and reset must mask them at once.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ALUOp    = 1'b0;
    AccSrc   = 3'd0;
    AccWrite = 1'b0;
    SpWrite  = 1'b0;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    if (!reset) begin
      MemRead = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'd1;
          end
        end
        DECODE: begin
          if (Op == OP_LI) begin
            AccSrc   = 3'd3;
            AccWrite = 1'b1;
          end else if (Op == OP_LUI) begin
            AccSrc   = 3'd0;
            AccWrite = 1'b1;
          end
        end
        MEM_RD: begin
          IorD     = 1'b1;
          MemRead  = 1'b1;
          MDRWrite = MemReady;
        end
        MEM_WB: begin
          AccSrc   = 3'd1;
          AccWrite = 1'b1;
        end
        MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        ALU_EX: begin
          ALUSrcA  = 2'd1;
          ALUSrcB  = (Op == OP_ADDI) ? 2'd0 : 2'd2;
          ALUOp    = (Op == OP_SUB);
          AccSrc   = 3'd4;
          AccWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcB = 2'd3;
          PCWrite = AccZero;
        end
        SP_EX: begin
          ALUSrcA = 2'd2;
          SpWrite = 1'b1;
        end
        HALT: Halted = 1'b1;
        ILLEGAL: begin
          Halted  = 1'b1;
          Illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level model queues the
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_control_unit;

  typedef struct packed {
    logic [3:0] state;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       mdrWrite;
    logic       pcWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       aluOp;
    logic [2:0] accSrc;
    logic       accWrite;
    logic       spWrite;
    logic       halted;
    logic       illegal;
  } obsT;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_RD = 4'd2,
                         S_MEM_WB = 4'd3, S_MEM_WR = 4'd4, S_ALU_EX = 4'd5,
                         S_BRANCH = 4'd6, S_SP_EX = 4'd7, S_HALT = 4'd8,
                         S_ILLEGAL = 4'd9;
  localparam logic [7:0] OP_LI = 8'h01, OP_LUI = 8'h02, OP_LW = 8'h03,
                         OP_SW = 8'h04, OP_ADD = 8'h05, OP_ADDI = 8'h06,
                         OP_BEQZ = 8'h07, OP_ADDSP = 8'h08, OP_SUB = 8'h09,
                         OP_HALT = 8'hFF;

  logic       CLK = 1'b1;
  logic       reset = 1'b0;
  logic [7:0] Op = 8'h00;
  logic       MemReady = 1'b0;
  logic       AccZero = 1'b0;
  logic       MemRead, MemWrite, IorD, IRWrite, MDRWrite, PCWrite;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic       ALUOp;
  logic [2:0] AccSrc;
  logic       AccWrite, SpWrite, Halted, Illegal;
  logic [3:0] State;

  control_unit #(.HALT_OP(OP_HALT)) dut (
    .CLK(CLK), .reset(reset), .Op(Op), .MemReady(MemReady), .AccZero(AccZero),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .MDRWrite(MDRWrite), .PCWrite(PCWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .AccSrc(AccSrc), .AccWrite(AccWrite), .SpWrite(SpWrite),
    .Halted(Halted), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  obsT expQ[$];
  int  passCount = 0;
  int  checkCount = 0;
  int  cycleNo = 0;
  obsT monGot, monExp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic obsT sample();
    return {State, MemRead, MemWrite, IorD, IRWrite, MDRWrite, PCWrite,
            ALUSrcA, ALUSrcB, ALUOp, AccSrc, AccWrite, SpWrite, Halted, Illegal};
  endfunction

  function automatic obsT mk(input logic [3:0] s);
    obsT e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: one expected record per clock, compared mid-cycle.
  always @(negedge CLK) begin
    if (expQ.size() != 0) begin
      monExp = expQ.pop_front();
      monGot = sample();
      check($sformatf("cycle%0d_state%0d", cycleNo, monExp.state), 32'(monGot), 32'(monExp));
    end
    cycleNo++;
  end

  task automatic step(input logic [7:0] op, input logic rdy, input logic az, input obsT e);
    Op = op;
    MemReady = rdy;
    AccZero = az;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Fetch with fw wait cycles, then decode of op.
  task automatic fetchDecode(input logic [7:0] op, input int fw);
    obsT e = mk(S_FETCH);
    e.memRead = 1'b1;
    repeat (fw) step(8'($urandom), 1'b0, rb(), e);
    e.irWrite = 1'b1;
    e.pcWrite = 1'b1;
    e.aluSrcB = 2'd1;
    step(8'($urandom), 1'b1, rb(), e);
    e = mk(S_DECODE);
    if (op == OP_LI)  begin e.accSrc = 3'd3; e.accWrite = 1'b1; end
    if (op == OP_LUI) begin e.accSrc = 3'd0; e.accWrite = 1'b1; end
    step(op, rb(), rb(), e);
  endtask

  task automatic execute(input logic [7:0] op, input int mw, input logic az);
    obsT e;
    if (op == OP_LW || op == OP_ADD || op == OP_SUB) begin
      e = mk(S_MEM_RD);
      e.iorD = 1'b1;
      e.memRead = 1'b1;
      repeat (mw) step(op, 1'b0, rb(), e);
      e.mdrWrite = 1'b1;
      step(op, 1'b1, rb(), e);
      if (op == OP_LW) begin
        e = mk(S_MEM_WB);
        e.accSrc = 3'd1;
      end else begin
        e = mk(S_ALU_EX);
        e.aluSrcA = 2'd1;
        e.aluSrcB = 2'd2;
        e.aluOp = (op == OP_SUB);
        e.accSrc = 3'd4;
      end
      e.accWrite = 1'b1;
      step(op, rb(), rb(), e);
    end else if (op == OP_SW) begin
      e = mk(S_MEM_WR);
      e.iorD = 1'b1;
      e.memWrite = 1'b1;
      repeat (mw) step(op, 1'b0, rb(), e);
      step(op, 1'b1, rb(), e);
    end else if (op == OP_ADDI) begin
      e = mk(S_ALU_EX);
      e.aluSrcA = 2'd1;
      e.accSrc = 3'd4;
      e.accWrite = 1'b1;
      step(op, rb(), rb(), e);
    end else if (op == OP_BEQZ) begin
      e = mk(S_BRANCH);
      e.aluSrcB = 2'd3;
      e.pcWrite = az;
      step(op, rb(), az, e);
    end else if (op == OP_ADDSP) begin
      e = mk(S_SP_EX);
      e.aluSrcA = 2'd2;
      e.spWrite = 1'b1;
      step(op, rb(), rb(), e);
    end
  endtask

  task automatic runInstr(input logic [7:0] op, input int fw, input int mw, input logic az);
    fetchDecode(op, fw);
    execute(op, mw, az);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic pulseReset(input string name);
    obsT e = mk(S_FETCH);
    e.memRead = 1'b1;
    #1;
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    check({name, "_async"}, 32'(sample()), 32'(e));
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  task automatic runStop(input logic [7:0] op, input int n);
    obsT e;
    fetchDecode(op, int'($urandom_range(0, 1)));
    e = mk((op == OP_HALT) ? S_HALT : S_ILLEGAL);
    e.halted = 1'b1;
    e.illegal = (op != OP_HALT);
    repeat (n) step(8'($urandom), rb(), rb(), e);
    pulseReset($sformatf("stop%02h_reset", op));
  endtask

  logic [7:0] opTable [9] = '{OP_LI, OP_LUI, OP_LW, OP_SW, OP_ADD,
                              OP_ADDI, OP_BEQZ, OP_ADDSP, OP_SUB};

  initial begin
    obsT e;
    e = mk(S_FETCH);
    e.memRead = 1'b1;
    reset = 1'b0;
    MemReady = 1'b1;
    AccZero = 1'b1;
    #1;
    check("reset_initial", 32'(sample()), 32'(e));
    step(8'h55, 1'b1, 1'b1, e);
    step(8'h01, 1'b1, 1'b0, e);
    reset = 1'b1;

    runInstr(OP_LW, 2, 0, rb());
    runInstr(OP_BEQZ, 0, 0, 1'b1);
    runInstr(OP_BEQZ, 1, 0, 1'b0);
    runInstr(OP_SUB, 0, 1, 1'b0);
    runInstr(OP_ADD, 0, 0, 1'b0);
    runInstr(OP_ADDI, 0, 0, 1'b0);
    runInstr(OP_SW, 0, 0, 1'b0);
    runInstr(OP_SW, 0, 2, 1'b0);
    runInstr(OP_LUI, 0, 0, 1'b0);
    runInstr(OP_ADDSP, 0, 0, 1'b0);
    runInstr(OP_LI, 0, 0, 1'b0);

    // Abort a stalled store and a stalled fetch.
    fetchDecode(OP_SW, 0);
    e = mk(S_MEM_WR);
    e.iorD = 1'b1;
    e.memWrite = 1'b1;
    step(OP_SW, 1'b0, rb(), e);
    step(OP_SW, 1'b0, rb(), e);
    pulseReset("memwr_abort");
    runInstr(OP_LI, 0, 0, 1'b0);
    e = mk(S_FETCH);
    e.memRead = 1'b1;
    step(8'($urandom), 1'b0, rb(), e);
    pulseReset("fetch_abort");

    runStop(8'h0A, 10);
    runInstr(OP_ADDI, 0, 0, 1'b0);
    runStop(OP_HALT, 10);
    runStop(8'($urandom_range(10, 254)), 4);

    for (int i = 0; i < 60; i++) begin
      runInstr(opTable[$urandom_range(0, 8)], int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), rb());
    end

    @(negedge CLK);
    #1;
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
